// File: rtl/act_feeder_pkg.sv
// Shared widths and helpers for the activation feeder.
// ARRAYWIDTH and DATASIZE mirror the array-wide geometry used by input_buffer.
package act_feeder_pkg;

    localparam int unsigned ARRAYWIDTH = 4;
    localparam int unsigned DATASIZE   = 8;
    localparam int unsigned ACT_W      = ARRAYWIDTH * DATASIZE;

    // Counter width for a terminal value; at least one bit so ROWS=1 still elaborates.
    function automatic int unsigned cnt_width(input int unsigned terminal);
        return (terminal > 0) ? $clog2(terminal + 1) : 1;
    endfunction

endpackage

// File: rtl/act_feeder_tile_counter.sv
// Saturating tile counter: counts enabled cycles up to Terminal and flags the last value.
// Holds at Terminal instead of wrapping so a tile never re-enters count zero.
module act_feeder_tile_counter
    import act_feeder_pkg::*;
#(
    parameter int unsigned Terminal = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o
);

    localparam int unsigned Width = cnt_width(Terminal);

    logic [Width-1:0] cnt_d, cnt_q;

    assign last_o = (cnt_q == Width'(Terminal));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !last_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/act_feeder.sv
// Tile sequencer in front of input_buffer: loads ROWS activation rows from a valid/ready
// stream, then drives out_en for ROWS+ARRAYWIDTH-1 unstalled cycles to drain the skew.
module act_feeder
    import act_feeder_pkg::*;
#(
    parameter int unsigned ROWS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             hold,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [ACT_W-1:0] s_data,
    output logic             load_en,
    output logic             out_en,
    output logic [ACT_W-1:0] in_act,
    output logic             busy,
    output logic             done
);

    localparam int unsigned DRAIN_CYCLES = ROWS + ARRAYWIDTH - 1;

    typedef enum logic [2:0] {StIdle, StLoad, StSettle, StDrain, StDone} state_e;

    state_e           state_d, state_q;
    logic             load_en_d, load_en_q;
    logic [ACT_W-1:0] in_act_d, in_act_q;
    logic             row_inc, row_last, drain_last;

    assign row_inc = (state_q == StLoad) && s_valid;
    assign busy    = (state_q != StIdle);
    assign load_en = load_en_q;
    assign in_act  = in_act_q;

    act_feeder_tile_counter #(
        .Terminal (ROWS - 1)
    ) u_row_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (state_q == StIdle),
        .en_i   (row_inc),
        .last_o (row_last)
    );

    act_feeder_tile_counter #(
        .Terminal (DRAIN_CYCLES - 1)
    ) u_drain_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (state_q == StSettle),
        .en_i   (out_en),
        .last_o (drain_last)
    );

    always_comb begin
        state_d   = state_q;
        s_ready   = 1'b0;
        out_en    = 1'b0;
        done      = 1'b0;
        load_en_d = 1'b0;
        in_act_d  = in_act_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StLoad;
            end
            StLoad: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    load_en_d = 1'b1;
                    in_act_d  = s_data;
                    if (row_last) state_d = StSettle;
                end
            end
            StSettle: begin
                state_d = StDrain;
            end
            StDrain: begin
                // Stall is combinational so the array sees it in the same cycle.
                out_en = !hold;
                if (!hold && drain_last) state_d = StDone;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            load_en_q <= 1'b0;
            in_act_q  <= '0;
        end else begin
            state_q   <= state_d;
            load_en_q <= load_en_d;
            in_act_q  <= in_act_d;
        end
    end

endmodule

// File: doc/act_feeder.md
# act_feeder

Sequencer that sits directly upstream of `input_buffer`. It accepts a tile of activation rows from a valid/ready stream and writes them into the per-row shift registers with `load_en`. It then asserts `out_en` for exactly the number of cycles needed to push the whole skewed tile into the systolic array. It provides start/busy/done control to the top-level controller and a `hold` input for array back-pressure.

## Interface
Parameters:
- `ROWS`, default 4: activation vectors per tile (≥1).
- `ARRAYWIDTH` and `DATASIZE`: taken from the shared `config.v` macros; not parameters.

Ports:
- `clk`  input  1  single clock; all logic is rising-edge.
- `rst`  input  1  asynchronous, active-low reset.
- `start`  input  1  begins a tile; sampled only in IDLE.
- `hold`  input  1  array stall; freezes drain while high.
- `s_valid`  input  1  upstream row valid.
- `s_ready`  output  1  feeder can accept a row.
- `s_data`  input  `ARRAYWIDTH*`DATASIZE  one activation row; lane i is at `[(i+1)*DATASIZE-1 : i*DATASIZE]`.
- `load_en`  output  1  to `input_buffer.load_en`.
- `out_en`  output  1  to `input_buffer.out_en`.
- `in_act`  output  `ARRAYWIDTH*`DATASIZE  to `input_buffer.in_act`.
- `busy`  output  1  high in any state other than IDLE.
- `done`  output  1  one-cycle pulse when the tile is fully drained.

## Operation
- FSM states: IDLE, LOAD, SETTLE, DRAIN, DONE.
- **IDLE**
  - `s_ready` = 0.
  - `start` = 1 → LOAD; `row_cnt` ← 0.
- **LOAD**
  - `s_ready` = 1.
  - Each accepted beat (`s_valid` && `s_ready`): register `s_data` into `in_act`, set `load_en` for the next cycle, increment `row_cnt`.
  - When the accepted beat is row `ROWS-1` → SETTLE.
  - Cycles with `s_valid` = 0 insert gaps with `load_en` = 0.
- **SETTLE**
  - One cycle; `s_ready` = 0.
  - The final registered `load_en` is high in this cycle.
  - → DRAIN; `drain_cnt` ← 0.
- **DRAIN**
  - `out_en` = !`hold`; this is combinational from the state register and `hold`.
  - `drain_cnt` increments only on cycles where `out_en` = 1.
  - When `drain_cnt` reaches `DRAIN_CYCLES-1` with `out_en` = 1 → DONE.
  - `DRAIN_CYCLES` = `ROWS` + `ARRAYWIDTH` - 1.
- **DONE**
  - `done` = 1 for one cycle → IDLE.
- `load_en` and `out_en` are never high in the same cycle.
- `in_act` holds its last value when `load_en` = 0.
- `start` is ignored while `busy`. `hold` is ignored outside DRAIN.
- Counter widths are `$clog2` of the terminal value + 1; counters never wrap inside a tile.

## Timing
- Reset (async assert, sync release): state = IDLE, `row_cnt` = `drain_cnt` = 0, `load_en` = 0, `in_act` = 0, and `s_ready` = `out_en` = `busy` = `done` = 0.
- `start` sampled at cycle t: `busy` and `s_ready` are high at t+1.
- Beat accepted at cycle t: `load_en` = 1 and `in_act` = that row at t+1. Latency is 1.
- Minimum tile length, from `start` to the `done` pulse: 1 + `ROWS` + 1 + `DRAIN_CYCLES` + 1 cycles, with no gaps and no hold.
- Reset asserted mid-tile: everything returns to reset values immediately. No `done` is produced. A partial tile is discarded, and the next `start` reloads from row 0.
- Reset takes priority over `start` when both occur in the same cycle.

## Structure
- Shared constants stay in `config.v`: `ARRAYWIDTH` and `DATASIZE`. No new macros.
- State encoding and `DRAIN_CYCLES` are module-local localparams.
- One sub-module is natural: `tile_counter`.
  - Parameterised terminal count, enable, clear, and a `last` flag.
  - Instantiated twice: once for rows, once for drain.

## Test plan
All scenarios use `ARRAYWIDTH`=4, `DATASIZE`=8, `ROWS`=4, so `DRAIN_CYCLES`=7.
- Reset check: hold `rst`=0 with random inputs → all outputs 0. Release reset and pulse `start` → `s_ready`=1 the next cycle.
- Back-to-back load: feed rows 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D with `s_valid` always high → four consecutive `load_en` pulses with matching `in_act`, one SETTLE cycle, 7 `out_en` cycles, then `done` 14 cycles after `start`.
- Gapped input: drop `s_valid` for 2 cycles between rows 1 and 2 → `load_en` is low for those 2 cycles, and total `out_en` count is still 7.
- Hold in drain: assert `hold` for 3 cycles mid-drain → `out_en` is low for exactly those cycles, total `out_en` = 7, and `done` is delayed by 3.
- Reset mid-drain: assert `rst` after 3 `out_en` cycles → outputs return to 0 at once and no `done` appears. A new `start` gives a full 4-row load.
- Spurious control: pulse `start` during LOAD and DRAIN, and `hold` during LOAD → behaviour is identical to the back-to-back load case.
